// File: rtl/mlt_operand_dispatcher.sv
// mlt_operand_dispatcher
// Feeds a repeated-addition multiplier from a small operand FIFO. It runs one
// start/done handshake per pair and holds the product on a valid/ready port.
// Optional feature macro: MLT_ZERO_BYPASS_EN. When it is defined, a pair with
// a zero operand is answered locally with 0 and the multiplier is not started.
module mlt_operand_dispatcher #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   mlt_start,
    output logic [WIDTH-1:0]       mlt_ain,
    output logic [WIDTH-1:0]       mlt_bin,
    input  logic                   mlt_done,
    input  logic [WIDTH-1:0]       mlt_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_mlt_start;
    logic [WIDTH-1:0] r_mlt_ain;
    logic [WIDTH-1:0] r_mlt_bin;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_busy;

    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic             w_zero_head;

    // in_ready looks only at the registered occupancy, never at a same-cycle pop.
    assign w_in_ready = (r_count < CW'(DEPTH));
    assign w_push     = in_valid && w_in_ready;
    // A pair leaves the FIFO only when the sequencer can take it and the
    // single result register is free.
    assign w_pop      = (r_state == ST_IDLE) && (r_count != {CW{1'b0}}) && !r_out_valid;
    assign w_head_a   = r_mem_a[r_rd_ptr];
    assign w_head_b   = r_mem_b[r_rd_ptr];

`ifdef MLT_ZERO_BYPASS_EN
    assign w_zero_head = (w_head_a == {WIDTH{1'b0}}) || (w_head_b == {WIDTH{1'b0}});
`else
    assign w_zero_head = 1'b0;
`endif

    // Operand storage: write the incoming pair at the tail pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i] <= {WIDTH{1'b0}};
                r_mem_b[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer: dispatch the head pair, run one multiplier handshake, capture the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mlt_start <= 1'b0;
            r_mlt_ain   <= {WIDTH{1'b0}};
            r_mlt_bin   <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            // The consumer takes the result. A new capture can only happen
            // while out_valid is already low, so the two never collide.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        if (w_zero_head) begin
                            r_out_data  <= {WIDTH{1'b0}};
                            r_out_valid <= 1'b1;
                        end else begin
                            r_mlt_ain   <= w_head_a;
                            r_mlt_bin   <= w_head_b;
                            r_mlt_start <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    // A done that is still high belongs to the previous
                    // operation. Keep requesting until the multiplier drops it.
                    if (!mlt_done) begin
                        r_mlt_start <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mlt_done) begin
                        r_out_data  <= mlt_data;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_mlt_start <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign mlt_start = r_mlt_start;
    assign mlt_ain   = r_mlt_ain;
    assign mlt_bin   = r_mlt_bin;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign count     = r_count;

endmodule

// File: tb/tb_mlt_operand_dispatcher.sv
// Testbench for mlt_operand_dispatcher. It uses a behavioural multiplier whose
// done level stays high after each result and whose stale-done hold can be set.
// A product scoreboard is built from the accepted input pairs.
module tb_mlt_operand_dispatcher;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_a      = 16'd0;
    logic [WIDTH-1:0] in_b      = 16'd0;
    logic             mlt_done  = 1'b0;
    logic [WIDTH-1:0] mlt_data  = 16'd0;
    logic             in_ready, mlt_start, out_valid, busy;
    logic [WIDTH-1:0] mlt_ain, mlt_bin, out_data;
    logic [CW-1:0]    count;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int hold_err    = 0;
    int start_phases = 0;
    int start_len   = 0;
    int stale_cfg   = 0;
    logic [WIDTH-1:0] exp_q [$];

    always #5 clk = ~clk;

    mlt_operand_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mlt_start(mlt_start), .mlt_ain(mlt_ain),
        .mlt_bin(mlt_bin), .mlt_done(mlt_done), .mlt_data(mlt_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .count(count)
    );

    // Multiplier model: the result comes b+3 cycles after start is accepted,
    // and done stays high until the next start is accepted.
    logic             m_run   = 1'b0;
    int               m_cnt   = 0;
    int               m_stale = 0;
    logic [WIDTH-1:0] m_prod  = 16'd0;
    always @(posedge clk) begin
        if (m_run) begin
            if (m_cnt <= 1) begin
                m_run    <= 1'b0;
                mlt_done <= 1'b1;
                mlt_data <= m_prod;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mlt_start) begin
            if (mlt_done && (m_stale < stale_cfg)) begin
                m_stale <= m_stale + 1;
            end else begin
                m_stale  <= 0;
                m_run    <= 1'b1;
                mlt_done <= 1'b0;
                m_cnt    <= int'(mlt_bin) + 3;
                m_prod   <= WIDTH'(longint'(mlt_ain) * longint'(mlt_bin));
                mlt_data <= ~mlt_data ^ 16'h5A5A;
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // One clock: read the pre-edge handshakes, step the edge, then update
    // the scoreboard and the hold invariants at #1 after the edge.
    task automatic tick();
        bit               pre_rst   = reset;
        bit               pre_push  = in_valid && in_ready;
        bit               pre_pop   = out_valid && out_ready;
        bit               pre_ov    = out_valid;
        bit               pre_or    = out_ready;
        bit               pre_busy  = busy;
        bit               pre_start = mlt_start;
        logic [WIDTH-1:0] pa = in_a, pb = in_b, pd = out_data;
        logic [WIDTH-1:0] pain = mlt_ain, pbin = mlt_bin;
        @(posedge clk);
        #1;
        if (!pre_rst && !reset) begin
            if (pre_push) exp_q.push_back(WIDTH'(longint'(pa) * longint'(pb)));
            if (pre_pop) begin
                check("sb_result_pending", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("sb_result", pd, exp_q.pop_front());
            end
            if (pre_ov && !pre_or && !(out_valid && out_data == pd)) hold_err++;
            if (pre_busy && busy && (mlt_ain != pain || mlt_bin != pbin)) hold_err++;
            if (mlt_start && !busy) hold_err++;
            if (in_ready != (count < CW'(DEPTH))) hold_err++;
            if (mlt_start) begin
                if (pre_start) start_len++;
                else begin
                    start_len = 1;
                    start_phases++;
                end
            end
        end
    endtask

    task automatic wait_out(input string nm, input int bound);
        int n = 0;
        while (!out_valid && n < bound) begin
            tick();
            n++;
        end
        check(nm, out_valid, 1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || busy || out_valid || count != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs [8];
    int   ord_exp [4];
    int   got [4];

    initial begin
        int sp0, n, idx, cyc;
        bit pushed;

        vecs[0] = '{16'd7,      16'd5,     16'd35};
        vecs[1] = '{16'd3,      16'd4,     16'd12};
        vecs[2] = '{16'd255,    16'd255,   16'd65025};
        vecs[3] = '{16'hFFFF,   16'd3,     16'd65533};
        vecs[4] = '{16'd300,    16'd300,   16'd24464};
        vecs[5] = '{16'h1234,   16'h0010,  16'h2340};
        vecs[6] = '{16'd1,      16'd1,     16'd1};
        vecs[7] = '{16'd100,    16'd2,     16'd200};
        ord_exp[0] = 12; ord_exp[1] = 100; ord_exp[2] = 18; ord_exp[3] = 200;

        // Reset values.
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mlt_start", mlt_start, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_out_data", out_data, 0);

        // Single operations from the table.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sp0 = start_phases;
            in_a = vecs[i].a; in_b = vecs[i].b; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!mlt_start && n < 4) begin tick(); n++; end
            check("vec_start_seen", mlt_start, 1);
            check("vec_ain", mlt_ain, vecs[i].a);
            check("vec_bin", mlt_bin, vecs[i].b);
            wait_out("vec_out_valid", 400);
            check("vec_out_data", out_data, vecs[i].exp);
            tick();
            check("vec_start_phases", start_phases - sp0, 1);
            check("vec_out_cleared", out_valid, 0);
        end
        drain("vec_drain");

        // Order and backpressure.
        out_ready = 1'b0;
        sp0 = start_phases;
        for (int i = 0; i < 4; i++) begin
            in_a = (i == 0) ? 16'd3 : (i == 1) ? 16'd10 : (i == 2) ? 16'd2 : 16'd100;
            in_b = (i == 0) ? 16'd4 : (i == 1) ? 16'd10 : (i == 2) ? 16'd9 : 16'd2;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("order_count_after_push", count, 3);
        wait_out("order_first_valid", 200);
        repeat (30) tick();
        check("order_single_dispatch", start_phases - sp0, 1);
        check("order_count_held", count, 3);
        check("order_out_held", out_data, 12);
        out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 600) begin
            if (out_valid) begin got[n] = int'(out_data); n++; end
            tick();
            cyc++;
        end
        check("order_result_count", n, 4);
        for (int i = 0; i < 4; i++) check("order_result", got[i], ord_exp[i]);
        drain("order_drain");

        // Full FIFO, then a simultaneous push and pop at DEPTH-1.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (idx < DEPTH + 2) begin
                in_valid = 1'b1; in_a = 16'(idx + 1); in_b = 16'd1;
            end else in_valid = 1'b0;
            pushed = in_valid && in_ready;
            tick();
            if (pushed) idx++;
        end
        in_valid = 1'b0;
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_accepted", idx, DEPTH + 1);
        check("full_result_pending", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        wait_out("full_second_valid", 100);
        check("full_count_after_pop", count, DEPTH - 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'd6; in_b = 16'd1;
        tick();
        in_valid = 1'b0;
        check("full_push_pop_count", count, DEPTH - 1);
        check("full_push_pop_dispatch", mlt_start, 1);
        drain("full_drain");

        // Stale done held for three extra cycles.
        stale_cfg = 3;
        sp0 = start_phases;
        in_a = 16'd6; in_b = 16'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("stale_out_valid", 200);
        check("stale_out_data", out_data, 42);
        check("stale_start_held", longint'(start_len >= 4), 1);
        tick();
        check("stale_start_phases", start_phases - sp0, 1);
        stale_cfg = 0;
        drain("stale_drain");

        // Reset while waiting on (9,9) with two pairs queued.
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; tick();
        in_a = 16'd1; in_b = 16'd2; tick();
        in_a = 16'd3; in_b = 16'd4; tick();
        in_valid = 1'b0;
        n = 0;
        while (!(busy && !mlt_start) && n < 20) begin tick(); n++; end
        check("rstw_in_wait", busy && !mlt_start, 1);
        check("rstw_queued", count, 2);
        reset = 1'b1;
        tick();
        check("rstw_count", count, 0);
        check("rstw_out_valid", out_valid, 0);
        check("rstw_mlt_start", mlt_start, 0);
        check("rstw_in_ready", in_ready, 1);
        check("rstw_busy", busy, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (30) tick();

        // Zero operand.
        sp0 = start_phases;
        in_a = 16'd0; in_b = 16'd50; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("zero_out_valid", 200);
        check("zero_out_data", out_data, 0);
        tick();
`ifdef MLT_ZERO_BYPASS_EN
        check("zero_start_phases", start_phases - sp0, 0);
`else
        check("zero_start_phases", start_phases - sp0, 1);
`endif
        drain("zero_drain");

        // Random traffic against the product scoreboard.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
            in_b      = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            out_ready = ($urandom_range(0, 3) != 0);
            if (c % 100 == 0) stale_cfg = int'($urandom_range(0, 2));
            tick();
        end
        drain("rand_drain");
        check("rand_idle", busy, 0);

        check("hold_invariants", hold_err, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
